// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg: shared constants for the interrupt-capable GPIO block.
//   - register field positions for writedata / readdata
//   - edge-detect mode encodings and the mode qualification helper
package gpio_irq_pkg;

  localparam int unsigned WD_W = 5;
  localparam int unsigned RD_W = 6;

  // writedata field positions
  localparam int unsigned WD_DOUT    = 0;
  localparam int unsigned WD_OE      = 1;
  localparam int unsigned WD_MODE_LO = 2;
  localparam int unsigned WD_MODE_HI = 3;
  localparam int unsigned WD_CLR     = 4;

  // readdata field positions
  localparam int unsigned RD_IN      = 0;
  localparam int unsigned RD_OE      = 1;
  localparam int unsigned RD_MODE_LO = 2;
  localparam int unsigned RD_MODE_HI = 3;
  localparam int unsigned RD_PEND    = 4;
  localparam int unsigned RD_DOUT    = 5;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  // True when the observed edge qualifies under the pin's edge mode
  function automatic logic edge_hit(input logic [1:0] mode, input logic rise, input logic fall);
    case (mode_e'(mode))
      MODE_OFF:  return 1'b0;
      MODE_RISE: return rise;
      MODE_FALL: return fall;
      MODE_BOTH: return rise | fall;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gpio_irq_if.sv
// gpio_irq_if: Avalon-MM style per-pin register bus.
//   address   : pin index
//   write_n   : active-low write strobe
//   read_n    : active-low read strobe
//   writedata : register write field
//   readdata  : registered read data (latency 1)
interface gpio_irq_if
  import gpio_irq_pkg::*;
#(
  parameter int unsigned GPIO_ADDR = 3
);

  logic [GPIO_ADDR-1:0] address;
  logic                 write_n;
  logic                 read_n;
  logic [WD_W-1:0]      writedata;
  logic [RD_W-1:0]      readdata;

  modport master (
    output address, write_n, read_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, write_n, read_n, writedata,
    output readdata
  );

endinterface

// File: rtl/gpio_irq_filter.sv
// gpio_irq_filter: per-pin input synchroniser followed by an optional
// shared-tick debounce filter.
//   clk, reset_n : clock and asynchronous active-low reset
//   raw          : raw pin levels (asynchronous to clk)
//   filt         : synchronised (and, if enabled, debounced) pin levels
module gpio_irq_filter #(
  parameter int unsigned GPIO_WIDTH   = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_DIV = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [GPIO_WIDTH-1:0] raw,
  output logic [GPIO_WIDTH-1:0] filt
);

  logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_WIDTH-1:0] sync_out;

  // Synchroniser chain; stage 0 samples the raw pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= raw;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_DIV == 0) begin : g_bypass
    assign filt = sync_out;
  end else begin : g_debounce
    localparam int unsigned CNT_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

    logic [CNT_W-1:0]      cnt_q;
    logic                  tick_c;
    logic [GPIO_WIDTH-1:0] samp_q;
    logic [GPIO_WIDTH-1:0] filt_q;
    logic [GPIO_WIDTH-1:0] stable_c;

    assign tick_c   = (cnt_q == CNT_W'(DEBOUNCE_DIV - 1));
    // A bit is stable when the previous tick saw the same level
    assign stable_c = ~(samp_q ^ sync_out);

    // Shared prescaler and per-pin two-tick agreement filter
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q  <= '0;
        samp_q <= '0;
        filt_q <= '0;
      end else begin
        cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
        if (tick_c) begin
          samp_q <= sync_out;
          filt_q <= (filt_q & ~stable_c) | (sync_out & stable_c);
        end
      end
    end

    assign filt = filt_q;
  end

endmodule

// File: rtl/gpio_irq.sv
// gpio_irq: bit-addressed bidirectional GPIO with edge-triggered,
// sticky pending flags and a single level interrupt.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus          : per-pin register access (slave side)
//   irq          : level interrupt, high while any enabled pin is pending
//   bidir_port   : device pins, driven when oe is set, else Z
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH   = 8,
  parameter int unsigned GPIO_ADDR    = 3,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_DIV = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  gpio_irq_if.slave             bus,
  output logic                  irq,
  inout  wire  [GPIO_WIDTH-1:0] bidir_port
);

  logic [GPIO_WIDTH-1:0]      oe_q,   oe_d;
  logic [GPIO_WIDTH-1:0]      dout_q, dout_d;
  logic [GPIO_WIDTH-1:0]      pend_q, pend_d;
  logic [GPIO_WIDTH-1:0][1:0] mode_q, mode_d;
  logic [GPIO_WIDTH-1:0]      filt;
  logic [GPIO_WIDTH-1:0]      filt_d_q;
  logic [GPIO_WIDTH-1:0]      rise_c;
  logic [GPIO_WIDTH-1:0]      fall_c;
  logic [GPIO_WIDTH-1:0]      sel_c;
  logic [RD_W-1:0]            readdata_q, readdata_d;
  logic                       irq_d;
  logic                       wr_c;
  logic                       rd_c;

  gpio_irq_filter #(
    .GPIO_WIDTH   (GPIO_WIDTH),
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_DIV (DEBOUNCE_DIV)
  ) u_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (bidir_port),
    .filt    (filt)
  );

  // Pin drivers
  for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_pin
    assign bidir_port[g] = oe_q[g] ? dout_q[g] : 1'bz;
  end

  // Address decode; out-of-range addresses select no pin
  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < GPIO_WIDTH; i++) begin
      sel_c[i] = (bus.address == GPIO_ADDR'(i));
    end
  end

  assign wr_c   = ~bus.write_n;
  assign rd_c   = ~bus.read_n;
  assign rise_c = filt & ~filt_d_q;
  assign fall_c = ~filt & filt_d_q;

  // Register updates, edge capture, irq and read mux
  always_comb begin
    oe_d       = oe_q;
    dout_d     = dout_q;
    mode_d     = mode_q;
    pend_d     = pend_q;
    readdata_d = readdata_q;
    irq_d      = 1'b0;

    for (int unsigned i = 0; i < GPIO_WIDTH; i++) begin
      if (wr_c && sel_c[i]) begin
        oe_d[i]   = bus.writedata[WD_OE];
        dout_d[i] = bus.writedata[WD_DOUT];
        mode_d[i] = bus.writedata[WD_MODE_HI:WD_MODE_LO];
        if (bus.writedata[WD_CLR]) begin
          pend_d[i] = 1'b0;
        end
      end
      // A new edge overrides a clear issued in the same cycle
      if (edge_hit(mode_q[i], rise_c[i], fall_c[i])) begin
        pend_d[i] = 1'b1;
      end
      if (pend_q[i] && (mode_q[i] != MODE_OFF)) begin
        irq_d = 1'b1;
      end
    end

    // Reads see the state before any same-cycle write
    if (rd_c) begin
      readdata_d = '0;
      for (int unsigned i = 0; i < GPIO_WIDTH; i++) begin
        if (sel_c[i]) begin
          readdata_d[RD_IN]                 = filt[i];
          readdata_d[RD_OE]                 = oe_q[i];
          readdata_d[RD_MODE_HI:RD_MODE_LO] = mode_q[i];
          readdata_d[RD_PEND]               = pend_q[i];
          readdata_d[RD_DOUT]               = dout_q[i];
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oe_q       <= '0;
      dout_q     <= '0;
      mode_q     <= '0;
      pend_q     <= '0;
      filt_d_q   <= '0;
      readdata_q <= '0;
      irq        <= 1'b0;
    end else begin
      oe_q       <= oe_d;
      dout_q     <= dout_d;
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      filt_d_q   <= filt;
      readdata_q <= readdata_d;
      irq        <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: self-checking bench. dut0 has 6 pins with no debounce,
// dut1 has 8 pins with a 4-clock debounce tick.
module tb_gpio_irq;

  logic clk;
  logic reset_n;
  logic irq0, irq1;
  wire  [5:0] pins0;
  wire  [7:0] pins1;
  logic [7:0] ext_val0;
  logic [7:0] ext_val1;
  logic [7:0] sh_oe;

  int n_checks = 0;
  int n_err    = 0;

  gpio_irq_if #(.GPIO_ADDR(3)) bif0 ();
  gpio_irq_if #(.GPIO_ADDR(3)) bif1 ();

  gpio_irq #(.GPIO_WIDTH(6), .GPIO_ADDR(3), .SYNC_STAGES(2), .DEBOUNCE_DIV(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bif0), .irq(irq0), .bidir_port(pins0)
  );

  gpio_irq #(.GPIO_WIDTH(8), .GPIO_ADDR(3), .SYNC_STAGES(2), .DEBOUNCE_DIV(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bif1), .irq(irq1), .bidir_port(pins1)
  );

  // External drivers release a pin whenever the DUT is expected to drive it
  for (genvar g = 0; g < 6; g++) begin : g_ext0
    assign pins0[g] = sh_oe[g] ? 1'bz : ext_val0[g];
  end
  assign pins1 = ext_val1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] addr;
    logic [4:0] wd;
    logic [5:0] exp_rd;
    logic       exp_irq;
  } vec_t;

  vec_t tbl [11];

  // Reference model state (pin history gives the filter delay)
  logic [7:0] m_oe, m_dout, m_pend;
  logic [1:0] m_mode [8];
  logic [5:0] m_rd;
  logic       m_irq;
  logic [7:0] h0, h1, h2, h3;
  logic [7:0] pinv, f, fd, rise, fall, setv, npend;
  logic       nirq;
  logic [5:0] nrd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input int d, input logic [2:0] a, input logic [4:0] w);
    if (d == 0) begin
      bif0.address = a; bif0.writedata = w; bif0.write_n = 1'b0;
    end else begin
      bif1.address = a; bif1.writedata = w; bif1.write_n = 1'b0;
    end
    tick();
    bif0.write_n = 1'b1;
    bif1.write_n = 1'b1;
    if (d == 0 && a < 3'd6) sh_oe[a] = w[1];
  endtask

  task automatic bus_read(input int d, input logic [2:0] a);
    if (d == 0) begin
      bif0.address = a; bif0.read_n = 1'b0;
    end else begin
      bif1.address = a; bif1.read_n = 1'b0;
    end
    tick();
    bif0.read_n = 1'b1;
    bif1.read_n = 1'b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sh_oe   = '0;
    #1;
    idle(2);
    reset_n = 1'b1;
    idle(1);
  endtask

  initial begin
    bif0.address = '0; bif0.write_n = 1'b1; bif0.read_n = 1'b1; bif0.writedata = '0;
    bif1.address = '0; bif1.write_n = 1'b1; bif1.read_n = 1'b1; bif1.writedata = '0;
    ext_val0 = '0;
    ext_val1 = '0;
    sh_oe    = '0;
    reset_n  = 1'b0;
    #12;
    check("reset readdata", 32'(bif0.readdata), 32'h0);
    check("reset irq", 32'(irq0), 32'h0);
    reset_n = 1'b1;
    idle(2);

    // Drive and release pin 3
    bus_write(0, 3'd3, 5'b00011);
    check("pin3 drive high", 32'(pins0[3]), 32'h1);
    bus_write(0, 3'd3, 5'b00010);
    check("pin3 drive low", 32'(pins0[3]), 32'h0);

    // Write, settle, read back
    tbl[0]  = '{3'd3, 5'b00011, 6'b100011, 1'b0};
    tbl[1]  = '{3'd3, 5'b00000, 6'b000000, 1'b0};
    tbl[2]  = '{3'd1, 5'b01010, 6'b001010, 1'b0};
    tbl[3]  = '{3'd1, 5'b01011, 6'b101011, 1'b0};
    tbl[4]  = '{3'd1, 5'b01010, 6'b011010, 1'b1};
    tbl[5]  = '{3'd1, 5'b11000, 6'b001000, 1'b0};
    tbl[6]  = '{3'd7, 5'b11111, 6'b000000, 1'b0};
    tbl[7]  = '{3'd6, 5'b00011, 6'b000000, 1'b0};
    tbl[8]  = '{3'd0, 5'b00110, 6'b000110, 1'b0};
    tbl[9]  = '{3'd0, 5'b00111, 6'b110111, 1'b1};
    tbl[10] = '{3'd0, 5'b10000, 6'b000000, 1'b0};
    for (int k = 0; k < 11; k++) begin
      bus_write(0, tbl[k].addr, tbl[k].wd);
      idle(3);
      bus_read(0, tbl[k].addr);
      check($sformatf("tbl%0d readdata", k), 32'(bif0.readdata), 32'(tbl[k].exp_rd));
      check($sformatf("tbl%0d irq", k), 32'(irq0), 32'(tbl[k].exp_irq));
    end

    // Rising edge latency on pin 5 (mode rise)
    bus_write(0, 3'd5, 5'b00100);
    idle(4);
    bif0.address = 3'd5;
    bif0.read_n  = 1'b0;
    ext_val0[5]  = 1'b1;
    idle(2);
    check("p5 filt not yet", 32'(bif0.readdata[0]), 32'h0);
    tick();
    check("p5 filt set", 32'(bif0.readdata[0]), 32'h1);
    check("p5 pend not yet", 32'(bif0.readdata[4]), 32'h0);
    check("p5 irq not yet", 32'(irq0), 32'h0);
    tick();
    check("p5 pend set", 32'(bif0.readdata[4]), 32'h1);
    check("p5 irq set", 32'(irq0), 32'h1);
    bif0.read_n = 1'b1;
    bus_write(0, 3'd5, 5'b10100);
    check("p5 irq after clr edge", 32'(irq0), 32'h1);
    tick();
    check("p5 irq cleared", 32'(irq0), 32'h0);
    ext_val0[5] = 1'b0;
    idle(5);
    bus_read(0, 3'd5);
    check("p5 fall ignored", 32'(bif0.readdata), 32'b000100);
    check("p5 fall irq", 32'(irq0), 32'h0);

    // Both-edge mode on pin 0, then mask with mode off
    bus_write(0, 3'd0, 5'b01100);
    idle(3);
    ext_val0[0] = 1'b1;
    idle(4);
    bus_read(0, 3'd0);
    check("p0 rise pend", 32'(bif0.readdata), 32'b011101);
    check("p0 rise irq", 32'(irq0), 32'h1);
    bus_write(0, 3'd0, 5'b11100);
    tick();
    check("p0 clr irq", 32'(irq0), 32'h0);
    ext_val0[0] = 1'b0;
    idle(4);
    bus_read(0, 3'd0);
    check("p0 fall pend", 32'(bif0.readdata), 32'b011100);
    bus_write(0, 3'd0, 5'b00000);
    tick();
    check("p0 mask irq", 32'(irq0), 32'h0);
    bus_read(0, 3'd0);
    check("p0 masked pend kept", 32'(bif0.readdata), 32'b010000);
    bus_write(0, 3'd0, 5'b10000);

    // Edge and clear collide on pin 4
    bus_write(0, 3'd4, 5'b00100);
    idle(3);
    ext_val0[4] = 1'b1;
    idle(5);
    check("p4 first irq", 32'(irq0), 32'h1);
    ext_val0[4] = 1'b0;
    idle(5);
    ext_val0[4] = 1'b1;
    idle(2);
    bus_write(0, 3'd4, 5'b10100);
    check("p4 collide irq", 32'(irq0), 32'h1);
    bus_read(0, 3'd4);
    check("p4 collide pend", 32'(bif0.readdata), 32'b010101);
    check("p4 collide irq hold", 32'(irq0), 32'h1);

    // Reset in the middle of activity
    bus_write(0, 3'd3, 5'b00011);
    #2;
    reset_n = 1'b0;
    sh_oe   = '0;
    #1;
    check("midreset irq", 32'(irq0), 32'h0);
    check("midreset readdata", 32'(bif0.readdata), 32'h0);
    ext_val0 = '0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
    bus_read(0, 3'd3);
    check("midreset pin3 state", 32'(bif0.readdata), 32'h0);

    // Debounce on dut1 pin 2
    bus_write(1, 3'd2, 5'b01100);
    idle(8);
    ext_val1[2] = 1'b1;
    idle(3);
    ext_val1[2] = 1'b0;
    idle(12);
    bus_read(1, 3'd2);
    check("glitch rejected", 32'(bif1.readdata), 32'b001100);
    check("glitch irq", 32'(irq1), 32'h0);
    ext_val1[2] = 1'b1;
    idle(10);
    bus_read(1, 3'd2);
    check("steady accepted", 32'(bif1.readdata[0]), 32'h1);
    idle(2);
    bus_read(1, 3'd2);
    check("steady pend", 32'(bif1.readdata), 32'b011101);
    check("steady irq", 32'(irq1), 32'h1);

    // Randomised run against the reference model
    ext_val0 = '0;
    bif0.address = '0; bif0.writedata = '0;
    do_reset();
    m_oe = '0; m_dout = '0; m_pend = '0; m_rd = '0; m_irq = 1'b0;
    for (int i = 0; i < 8; i++) m_mode[i] = 2'b00;
    h0 = '0; h1 = '0; h2 = '0; h3 = '0;
    for (int c = 0; c < 3000; c++) begin
      automatic int         op = $urandom_range(0, 3);
      automatic logic [2:0] a  = 3'($urandom_range(0, 7));
      automatic logic [4:0] w  = 5'($urandom);
      automatic logic       wr = (op == 0) || (op == 2);
      automatic logic       rd = (op == 1) || (op == 2);
      bif0.address   = a;
      bif0.writedata = w;
      bif0.write_n   = ~wr;
      bif0.read_n    = ~rd;
      if ($urandom_range(0, 2) == 0) ext_val0 = ext_val0 ^ 8'(1 << $urandom_range(0, 5));
      @(posedge clk);
      pinv = (m_oe & m_dout) | (~m_oe & ext_val0);
      h3 = h2; h2 = h1; h1 = h0; h0 = pinv;
      f = h2; fd = h3;
      rise = f & ~fd;
      fall = ~f & fd;
      nirq = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (m_pend[i] && m_mode[i] != 2'b00) nirq = 1'b1;
        setv[i] = (m_mode[i][0] && rise[i]) || (m_mode[i][1] && fall[i]);
      end
      setv[7:6] = 2'b00;
      nrd = m_rd;
      if (rd) nrd = (a < 3'd6) ? {m_dout[a], m_pend[a], m_mode[a], m_oe[a], f[a]} : 6'h0;
      npend = m_pend;
      if (wr && a < 3'd6) begin
        if (w[4]) npend[a] = 1'b0;
        m_oe[a]   = w[1];
        m_dout[a] = w[0];
        m_mode[a] = w[3:2];
      end
      m_pend = npend | setv;
      m_irq  = nirq;
      m_rd   = nrd;
      #1;
      sh_oe = m_oe;
      check("rand readdata", 32'(bif0.readdata), 32'(m_rd));
      check("rand irq", 32'(irq0), 32'(m_irq));
    end
    bif0.write_n = 1'b1;
    bif0.read_n  = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_irq.md
Name: gpio_irq

Overview:
- Parametrised, bitwise-addressed bidirectional GPIO with a per-pin Avalon-MM register and one 32-bit word stride per pin (pin i at base + i*4).
- Extends plain set/drive/sample GPIO with:
  - input synchronisation,
  - an optional shared-tick debounce filter,
  - per-pin edge detection with sticky pending flags,
  - a single level interrupt.
- Serves the Linux generic GPIO plus gpio-irq layer for i2c/spi/1-wire bit-bang and button/interrupt inputs.

Parameters:
- GPIO_WIDTH, 8, number of pins (1..2^GPIO_ADDR).
- GPIO_ADDR, 3, pin address width.
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- DEBOUNCE_DIV, 0, clocks per debounce sample tick; 0 = filter bypassed.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  GPIO_ADDR  pin index.
- write_n  input  1  active-low write strobe.
- read_n  input  1  active-low read strobe.
- writedata  input  5  register write field.
- readdata  output  6  registered read data, read latency 1.
- irq  output  1  level interrupt, active high.
- bidir_port  inout  GPIO_WIDTH  device pins.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low. All state clears on reset, including mid-operation.
- Reset values:
  - readdata=0, irq=0, bidir_port all Z.
  - oe=0, dout=0, mode=00, pending=0.
  - Synchroniser, filter and prescaler registers all 0.
- Write (write_n=0, address<GPIO_WIDTH), one cycle, pin p=address:
  - oe[p]<=wd[1], dout[p]<=wd[0], mode[p]<=wd[3:2].
  - wd[4]=1 clears pending[p].
- Writes to address>=GPIO_WIDTH are ignored.
- Pin drive: bidir_port[i] = oe[i] ? dout[i] : Z. The pin changes one cycle after the write edge.
- Read (read_n=0), the cycle after the strobe: readdata = {dout[p], pending[p], mode[p], oe[p], filt[p]}, bit0 = filt.
  - address>=GPIO_WIDTH returns 0.
  - readdata holds its value when read_n=1.
- Synchroniser: SYNC_STAGES flops per pin on the raw pin value. This includes driven pins, so a read-back reflects the actual pin level.
- Debounce, DEBOUNCE_DIV=0: filt = sync output, i.e. SYNC_STAGES cycles of latency.
- Debounce, DEBOUNCE_DIV>0:
  - Shared prescaler counts 0..DEBOUNCE_DIV-1. tick is asserted when count = DEBOUNCE_DIV-1, then the counter wraps to 0.
  - On tick: samp[i]<=sync[i]; if samp[i]==sync[i] then filt[i]<=sync[i].
  - A level must be stable across two consecutive ticks to be accepted.
  - Glitches shorter than DEBOUNCE_DIV clocks are never accepted.
- Edge detect:
  - filt_d <= filt every cycle.
  - rise = filt & ~filt_d; fall = ~filt & filt_d.
  - Modes: 00 off, 01 rising, 10 falling, 11 both.
  - A qualifying edge sets pending[i] (sticky).
- Simultaneous edge and clear write on the same pin in the same cycle: set wins, pending stays 1.
- Mode change does not clear pending. Setting mode to 00 masks irq but does not clear pending.
- irq is registered: irq <= OR over i of (pending[i] & (mode[i]!=00)). This is one cycle after pending changes.
- Simultaneous read and write to the same pin: readdata shows pre-write state.

Decomposition:
- Package gpio_irq_pkg:
  - writedata/readdata bit positions (WD_DOUT=0, WD_OE=1, WD_MODE=3:2, WD_CLR=4; RD_IN=0, RD_OE=1, RD_MODE=3:2, RD_PEND=4, RD_DOUT=5).
  - Mode encodings MODE_OFF/RISE/FALL/BOTH.
- Sub-module gpio_irq_filter: synchroniser + prescaler + debounce, parametrised by GPIO_WIDTH, SYNC_STAGES, DEBOUNCE_DIV. Input raw pins, output filt vector.
- Top level holds registers, edge logic, irq, tristates.

Test Plan:
- Reset drive and release:
  - Reset, then write pin 3 wd=5'b00011 → bidir_port[3]=1 next cycle.
  - Read addr 3 → readdata=6'b100011.
  - Write wd=0 → pin 3 Z.
- Rising edge and clear, DEBOUNCE_DIV=0, pin 5 mode=01:
  - Drive ext 0→1 → readdata[0]=1 after 2 cycles; pending[5]=1 one cycle later; irq=1 one cycle after that.
  - Write wd[4]=1 with mode kept → irq=0 two cycles later.
  - Falling edge on pin 5 → no pending.
- Mode 11 on pin 0:
  - Toggle pin 0 twice, clearing pending between toggles → pending sets on both edges.
  - Mode 00 with pending=1 → irq drops, readdata[4] still 1.
- Debounce, DEBOUNCE_DIV=4:
  - 3-cycle glitch on pin 2 → filt never changes, no pending.
  - Steady level → accepted within 8+SYNC_STAGES cycles.
- Set vs clear collision: edge arrives in the same cycle as a clear write on the same pin → pending=1, irq remains 1.
- Out-of-range access and mid-operation reset (GPIO_WIDTH=6):
  - Write/read addr 7 → no state change, readdata=0.
  - Assert reset_n with irq=1 → irq, readdata and oe all 0 immediately, pins Z.
